// File: rtl/mmio_sw_led_slave_if.sv
// Processor data-bus bundle for the switch/LED responder: req/ack handshake,
// word address, store data and load data.
interface mmio_sw_led_slave_if;
  logic        req;
  logic        we;
  logic [15:0] addr;
  logic [15:0] wdata;
  logic        ack;
  logic [15:0] rdata;

  modport master (output req, output we, output addr, output wdata,
                  input  ack, input  rdata);
  modport slave  (input  req, input  we, input  addr, input  wdata,
                  output ack, output rdata);
endinterface

// File: rtl/mmio_sw_led_slave.sv
// Memory-mapped switch/LED responder: debounced SW, sticky change bits, LED register.
// Optional feature macro SWLED_IRQ_EN adds the irq output and a RW IRQ_MASK at offset 3.
module mmio_sw_led_slave #(
  parameter logic [15:0] BASE_ADDR  = 16'hC000,
  parameter int          DEB_CYCLES = 1000
) (
  input  logic                 clk,
  input  logic                 rst,
  mmio_sw_led_slave_if.slave   bus,
  input  logic [9:0]           SW,
  output logic [9:0]           LEDR
`ifdef SWLED_IRQ_EN
  ,
  output logic                 irq
`endif
);

  typedef enum logic {IDLE, ACK} state_t;

  localparam logic [9:0] CNT_MAX = 10'(DEB_CYCLES - 1);

  state_t      state, state_next;
  logic        sel, take;
  logic [1:0]  off;
  logic [15:0] rd_val, rdata_q;
  logic [9:0]  led_q;
  logic [9:0]  sw_m, sw_s, cand, cnt;
  logic [9:0]  sw_db, sw_db_next, sw_chg, sw_chg_next, chg_clr;
  logic        deb_hit;
  logic [9:0]  irq_mask;
  logic        unused_ok;

  assign off  = bus.addr[1:0];
  assign sel  = bus.req && (bus.addr[15:2] == BASE_ADDR[15:2]);
  // A held req is only considered from IDLE, so every access costs two cycles.
  assign take = (state == IDLE) && sel;

  assign unused_ok = &{1'b0, bus.wdata[15:10]};

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves
    // a value unassigned and no latch is inferred.
    state_next = state;
    rd_val     = '0;
    chg_clr    = '0;
    case (state)
      IDLE:    if (sel) state_next = ACK;
      ACK:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
    case (off)
      2'd0:    rd_val = {6'b0, led_q};
      2'd1:    rd_val = {6'b0, sw_db};
      2'd2:    rd_val = {6'b0, sw_chg};
      default: rd_val = {6'b0, irq_mask};
    endcase
    if (take && off == 2'd2)
      chg_clr = bus.we ? bus.wdata[9:0] : '1;
  end

  // A change detected in the same cycle as a clear survives: set wins.
  assign deb_hit     = (sw_s == cand) && (cnt == CNT_MAX);
  assign sw_db_next  = deb_hit ? cand : sw_db;
  assign sw_chg_next = (sw_chg & ~chg_clr) | (sw_db_next ^ sw_db);

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every flop samples the pre-edge value of every other flop.
  always_ff @(posedge clk) begin
    // NOTE: the synchroniser and debounce flops are reset too, so SW_DB starts
    // from a known 0 and re-qualifies the pins after every reset.
    if (rst) begin
      sw_m   <= '0;
      sw_s   <= '0;
      cand   <= '0;
      cnt    <= '0;
      sw_db  <= '0;
      sw_chg <= '0;
    end else begin
      sw_m   <= SW;
      sw_s   <= sw_m;
      cand   <= sw_s;
      if (sw_s != cand)      cnt <= '0;
      else if (cnt != CNT_MAX) cnt <= cnt + 10'd1;
      sw_db  <= sw_db_next;
      sw_chg <= sw_chg_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      rdata_q <= '0;
      led_q   <= '0;
    end else begin
      state <= state_next;
      if (take) begin
        rdata_q <= bus.we ? 16'h0000 : rd_val;
        if (bus.we && off == 2'd0) led_q <= bus.wdata[9:0];
      end
    end
  end

`ifdef SWLED_IRQ_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      irq_mask <= '0;
      irq      <= 1'b0;
    end else begin
      if (take && bus.we && off == 2'd3) irq_mask <= bus.wdata[9:0];
      irq <= |(sw_chg & irq_mask);
    end
  end
`else
  assign irq_mask = '0;
`endif

  assign bus.ack   = (state == ACK);
  assign bus.rdata = bus.ack ? rdata_q : 16'h0000;
  assign LEDR      = led_q;

endmodule

// File: tb/tb_mmio_sw_led_slave.sv
// Directed bench for mmio_sw_led_slave: expected load data is queued when an
// access is issued and compared by a monitor whenever bus_ack is seen.
module tb_mmio_sw_led_slave;
  localparam int DEB = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] sw;
  logic [9:0] ledr;
`ifdef SWLED_IRQ_EN
  logic       irq;
`endif

  mmio_sw_led_slave_if bus();

  mmio_sw_led_slave #(.BASE_ADDR(16'hC000), .DEB_CYCLES(DEB)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .SW   (sw),
    .LEDR (ledr)
`ifdef SWLED_IRQ_EN
    ,
    .irq  (irq)
`endif
  );

  always #5 clk = ~clk;

  int          assertions = 0;
  int          failures   = 0;
  logic [15:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    assertions++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns in the ack cycle; ack must follow the first sampling edge.
  task automatic access(input logic we, input logic [15:0] addr,
                        input logic [15:0] wdata, input logic [15:0] exp);
    int lat = 0;
    exp_q.push_back(exp);
    bus.we = we; bus.addr = addr; bus.wdata = wdata; bus.req = 1'b1;
    do begin
      tick();
      lat++;
    end while (!bus.ack && lat < 10);
    check("ack_latency", lat, 1);
    bus.req = 1'b0;
  endtask

  task automatic xfer(input logic we, input logic [15:0] addr,
                      input logic [15:0] wdata, input logic [15:0] exp);
    access(we, addr, wdata, exp);
    tick();
  endtask

  always @(negedge clk) begin
    if (bus.ack) begin
      if (exp_q.size() == 0) check("unexpected_ack", bus.ack, 1'b0);
      else check("rdata", bus.rdata, exp_q.pop_front());
    end else if (!rst) begin
      check("rdata_idle_zero", bus.rdata, 16'h0000);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; sw = 10'h155;
    bus.req = 1'b0; bus.we = 1'b0; bus.addr = 16'h0000; bus.wdata = 16'h0000;
    repeat (3) tick();
    check("reset_ledr", ledr, 10'h000);
    check("reset_ack", bus.ack, 1'b0);
    check("reset_rdata", bus.rdata, 16'h0000);
`ifdef SWLED_IRQ_EN
    check("reset_irq", irq, 1'b0);
`endif
    rst = 1'b0;

    access(1'b1, 16'hC000, 16'hFD55, 16'h0000);
    check("ledr_in_ack", ledr, 10'h155);
    tick();
    check("led_readback_pre", ledr, 10'h155);
    xfer(1'b0, 16'hC000, 16'h0000, 16'h0155);

    repeat (20) tick();
    xfer(1'b0, 16'hC002, 16'h0000, 16'h0155);

    sw = 10'h2AA;
    repeat (20) tick();
    xfer(1'b0, 16'hC001, 16'h0000, 16'h02AA);
    xfer(1'b0, 16'hC002, 16'h0000, 16'h03FF);
    xfer(1'b0, 16'hC002, 16'h0000, 16'h0000);
    xfer(1'b1, 16'hC001, 16'h0123, 16'h0000);
    xfer(1'b0, 16'hC001, 16'h0000, 16'h02AA);

    sw = 10'h2AB;
    repeat (5) tick();
    sw = 10'h2AA;
    repeat (20) tick();
    xfer(1'b0, 16'hC001, 16'h0000, 16'h02AA);
    xfer(1'b0, 16'hC002, 16'h0000, 16'h0000);

    // SW_DB takes the new value on the (DEB+3)th edge after the pins move;
    // the load below is sampled on exactly that edge.
    sw = 10'h2A2;
    repeat (DEB + 2) tick();
    xfer(1'b0, 16'hC002, 16'h0000, 16'h0000);
    xfer(1'b0, 16'hC002, 16'h0000, 16'h0008);
    xfer(1'b0, 16'hC001, 16'h0000, 16'h02A2);

    begin
      int acks = 0;
      bus.we = 1'b0; bus.addr = 16'hC004; bus.req = 1'b1;
      repeat (10) begin
        tick();
        if (bus.ack) acks++;
      end
      bus.req = 1'b0;
      check("out_of_range_acks", acks, 0);
      tick();
    end

    exp_q.push_back(16'h02A2);
    bus.we = 1'b0; bus.addr = 16'hC001; bus.req = 1'b1;
    tick();
    check("pre_reset_ack", bus.ack, 1'b1);
    rst = 1'b1;
    tick();
    check("ack_suppressed_by_reset", bus.ack, 1'b0);
    check("ledr_after_reset", ledr, 10'h000);
    exp_q.push_back(16'h0000);
    rst = 1'b0;
    tick();
    check("held_req_after_reset", bus.ack, 1'b1);
    bus.req = 1'b0;
    tick();

`ifdef SWLED_IRQ_EN
    repeat (20) tick();
    xfer(1'b0, 16'hC002, 16'h0000, 16'h02A2);
    xfer(1'b1, 16'hC003, 16'hFC01, 16'h0000);
    xfer(1'b0, 16'hC003, 16'h0000, 16'h0001);
    check("irq_idle", irq, 1'b0);
    sw = 10'h2A3;
    repeat (20) tick();
    check("irq_set", irq, 1'b1);
    access(1'b1, 16'hC002, 16'h0001, 16'h0000);
    check("irq_in_w1c_ack", irq, 1'b1);
    tick();
    check("irq_cleared", irq, 1'b0);
`else
    xfer(1'b1, 16'hC003, 16'h0001, 16'h0000);
    xfer(1'b0, 16'hC003, 16'h0000, 16'h0000);
`endif

    repeat (3) tick();
    check("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end
endmodule
